// File: rtl/filter_window_ctrl_if.sv
// Stream handshake, line-buffer control and result tags shared by
// filter_window_ctrl and whatever drives/consumes it.
interface filter_window_ctrl_if #(
   parameter int FILTER_DIM = 7,
   parameter int MAX_WIDTH  = 2048,
   parameter int CW         = $clog2(MAX_WIDTH),
   parameter int SW         = (FILTER_DIM > 3) ? $clog2(FILTER_DIM - 1) : 1
);
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tuser;
   logic          s_tlast;
   logic          dn_ready;
   logic          lb_we;
   logic [SW-1:0] lb_wsel;
   logic [CW-1:0] lb_addr;
   logic [SW-1:0] lb_rot;
   logic          win_en;
   logic          out_valid;
   logic          out_tuser;
   logic          out_tlast;
   logic [CW:0]   line_width;
   logic          err_sof;
   logic          err_eol_early;
   logic          err_eol_late;
   logic          busy;

   modport master (
      output s_tvalid, s_tuser, s_tlast, dn_ready,
      input  s_tready, lb_we, lb_wsel, lb_addr, lb_rot, win_en,
             out_valid, out_tuser, out_tlast, line_width,
             err_sof, err_eol_early, err_eol_late, busy
   );

   modport slave (
      input  s_tvalid, s_tuser, s_tlast, dn_ready,
      output s_tready, lb_we, lb_wsel, lb_addr, lb_rot, win_en,
             out_valid, out_tuser, out_tlast, line_width,
             err_sof, err_eol_early, err_eol_late, busy
   );
endinterface

// File: rtl/filter_window_ctrl.sv
// Position tracking and line-buffer/window sequencing for the FILTER_DIM x
// FILTER_DIM video filter; measures line width and flags framing errors.
module filter_window_ctrl #(
   parameter int FILTER_DIM = 7,
   parameter int MAX_WIDTH  = 2048,
   parameter int CW         = $clog2(MAX_WIDTH),
   parameter int SW         = (FILTER_DIM > 3) ? $clog2(FILTER_DIM - 1) : 1
) (
   input logic               clk,
   input logic               rst,
   filter_window_ctrl_if.slave io
);
   localparam int RW = $clog2(FILTER_DIM);
   localparam logic [CW:0]   ONE       = (CW+1)'(1);
   localparam logic [CW:0]   DIM_W     = (CW+1)'(FILTER_DIM);
   localparam logic [CW:0]   MAX_W     = (CW+1)'(MAX_WIDTH);
   localparam logic [CW-1:0] COL_MAX   = CW'(MAX_WIDTH - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(FILTER_DIM - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(FILTER_DIM - 1);
   localparam logic [SW-1:0] WSEL_LAST = SW'(FILTER_DIM - 2);

   typedef enum logic [1:0] {WAIT_SOF, FIRST_LINE, RUN} state_t;

   state_t        r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [SW-1:0] r_wsel;
   logic [CW:0]   r_width;
   logic          r_first;
   logic          r_out_valid, r_out_tuser, r_out_tlast;
   logic          r_err_sof, r_err_early, r_err_late;

   logic          w_acc, w_we, w_eol, w_res, w_last_col;
   logic [CW:0]   w_col_ext;
   logic [SW-1:0] w_wsel_nx;
   logic [RW-1:0] w_row_nx;

   always_comb begin
      w_acc      = io.s_tvalid && io.dn_ready;
      w_we       = w_acc && ((r_state != WAIT_SOF) || io.s_tuser);
      w_col_ext  = {1'b0, r_col};
      w_last_col = (w_col_ext == r_width - ONE);
      w_wsel_nx  = (r_wsel == WSEL_LAST) ? '0 : r_wsel + SW'(1);
      w_row_nx   = (r_row == ROW_LAST) ? r_row : r_row + RW'(1);
      w_res      = (r_row == ROW_LAST) && (r_col >= COL_FIRST) && !io.s_tuser;
      w_eol      = 1'b0;
      case (r_state)
         FIRST_LINE: w_eol = io.s_tlast || (r_col == COL_MAX);
         RUN:        w_eol = io.s_tlast || w_last_col;
         default:    w_eol = 1'b0;
      endcase
      // tuser restarts the frame, so that beat never closes a line
      if (io.s_tuser) w_eol = 1'b0;
   end

   assign io.s_tready      = io.dn_ready;
   assign io.lb_we         = w_we;
   assign io.win_en        = w_we;
   assign io.lb_addr       = io.s_tuser ? '0 : r_col;
   assign io.lb_wsel       = io.s_tuser ? '0 : r_wsel;
   assign io.lb_rot        = io.s_tuser ? '0 : r_wsel;
   assign io.out_valid     = r_out_valid;
   assign io.out_tuser     = r_out_tuser;
   assign io.out_tlast     = r_out_tlast;
   assign io.line_width    = r_width;
   assign io.err_sof       = r_err_sof;
   assign io.err_eol_early = r_err_early;
   assign io.err_eol_late  = r_err_late;
   assign io.busy          = (r_state != WAIT_SOF);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= WAIT_SOF;
         r_col       <= '0;
         r_row       <= '0;
         r_wsel      <= '0;
         r_width     <= '0;
         r_first     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_tuser <= 1'b0;
         r_out_tlast <= 1'b0;
         r_err_sof   <= 1'b0;
         r_err_early <= 1'b0;
         r_err_late  <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_tuser <= 1'b0;
         r_out_tlast <= 1'b0;
         r_err_sof   <= 1'b0;
         r_err_early <= 1'b0;
         r_err_late  <= 1'b0;
         if (w_acc) begin
            r_out_valid <= w_res;
            r_out_tuser <= w_res && r_first;
            r_out_tlast <= w_res && w_eol;
            if (w_res) r_first <= 1'b0;
            if (io.s_tuser) begin
               r_err_sof <= (r_state != WAIT_SOF) && ((r_col != '0) || (r_row != '0));
               r_state   <= FIRST_LINE;
               r_col     <= CW'(1);
               r_row     <= '0;
               r_wsel    <= '0;
               r_first   <= 1'b1;
            end else begin
               case (r_state)
                  FIRST_LINE: begin
                     if (io.s_tlast) r_width <= w_col_ext + ONE;
                     if (io.s_tlast && (w_col_ext + ONE < DIM_W)) begin
                        r_err_early <= 1'b1;
                        r_state     <= WAIT_SOF;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_wsel      <= '0;
                     end else if (w_eol) begin
                        if (!io.s_tlast) begin
                           r_err_late <= 1'b1;
                           r_width    <= MAX_W;
                        end
                        r_state <= RUN;
                        r_col   <= '0;
                        r_wsel  <= w_wsel_nx;
                        r_row   <= w_row_nx;
                     end else begin
                        r_col <= r_col + CW'(1);
                     end
                  end
                  RUN: begin
                     if (w_eol) begin
                        r_err_early <= io.s_tlast && !w_last_col;
                        r_err_late  <= !io.s_tlast;
                        r_col       <= '0;
                        r_wsel      <= w_wsel_nx;
                        r_row       <= w_row_nx;
                     end else begin
                        r_col <= r_col + CW'(1);
                     end
                  end
                  default: r_state <= WAIT_SOF;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_filter_window_ctrl.sv
// Randomized bench for filter_window_ctrl against a per-beat position model.
module tb_filter_window_ctrl;
   localparam int FD = 7;
   localparam int MW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   filter_window_ctrl_if #(.FILTER_DIM(FD), .MAX_WIDTH(MW)) io();
   filter_window_ctrl #(.FILTER_DIM(FD), .MAX_WIDTH(MW)) dut (
      .clk(clk),
      .rst(rst),
      .io (io)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_valid, n_tuser, n_tlast, n_err;

   // reference model: frame position with uncapped line count
   bit m_in, m_meas, m_first;
   int m_lw, m_x, m_y;
   bit p_valid, p_tuser, p_tlast, p_sof, p_early, p_late;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_pending();
      p_valid = 0; p_tuser = 0; p_tlast = 0; p_sof = 0; p_early = 0; p_late = 0;
   endtask

   task automatic model_reset();
      m_in = 0; m_meas = 0; m_first = 0; m_lw = 0; m_x = 0; m_y = 0;
      clear_pending();
   endtask

   task automatic model_step(input bit u, input bit l);
      bit res, eol;
      clear_pending();
      if (u) begin
         p_sof = m_in && !(m_x == 0 && m_y == 0);
         m_in = 1; m_meas = 1; m_first = 1; m_x = 1; m_y = 0;
         return;
      end
      if (!m_in) return;
      res = (m_y >= FD - 1) && (m_x >= FD - 1);
      eol = 0;
      if (m_meas) begin
         if (l) begin
            m_lw = m_x + 1;
            if (m_x + 1 < FD) begin
               p_early = 1; m_in = 0; m_x = 0; m_y = 0;
            end else begin
               m_meas = 0; eol = 1;
            end
         end else if (m_x == MW - 1) begin
            p_late = 1; m_lw = MW; m_meas = 0; eol = 1;
         end
      end else begin
         eol     = l || (m_x == m_lw - 1);
         p_early = l && (m_x < m_lw - 1);
         p_late  = !l && (m_x == m_lw - 1);
      end
      if (eol) begin
         m_x = 0; m_y++;
      end else if (m_in) begin
         m_x++;
      end
      p_valid = res;
      p_tuser = res && m_first;
      p_tlast = res && eol;
      if (res) m_first = 0;
   endtask

   task automatic check_regs();
      check_value("out_valid", io.out_valid, p_valid);
      check_value("out_tuser", io.out_tuser, p_tuser);
      check_value("out_tlast", io.out_tlast, p_tlast);
      check_value("err_sof", io.err_sof, p_sof);
      check_value("err_eol_early", io.err_eol_early, p_early);
      check_value("err_eol_late", io.err_eol_late, p_late);
      check_value("line_width", io.line_width, m_lw);
      check_value("busy", io.busy, m_in);
      n_valid += int'(io.out_valid);
      n_tuser += int'(io.out_tuser);
      n_tlast += int'(io.out_tlast);
      n_err   += int'(io.err_sof) + int'(io.err_eol_early) + int'(io.err_eol_late);
   endtask

   task automatic tick(input bit v, input bit u, input bit l, input bit dr, output bit acc);
      bit ewe;
      int eaddr, ewsel;
      @(negedge clk);
      check_regs();
      io.s_tvalid = v; io.s_tuser = u; io.s_tlast = l; io.dn_ready = dr;
      #1;
      acc   = v && dr;
      ewe   = m_in || u;
      eaddr = (u || !m_in) ? 0 : m_x;
      ewsel = (u || !m_in) ? 0 : (m_y % (FD - 1));
      check_value("s_tready", io.s_tready, dr);
      check_value("lb_we", io.lb_we, acc && ewe);
      check_value("win_en", io.win_en, acc && ewe);
      if (acc && ewe) begin
         check_value("lb_addr", io.lb_addr, eaddr);
         check_value("lb_wsel", io.lb_wsel, ewsel);
         check_value("lb_rot", io.lb_rot, ewsel);
      end
      if (acc) model_step(u, l);
      else clear_pending();
   endtask

   task automatic send_beat(input bit u, input bit l, input bit rnd);
      bit a;
      int n;
      n = 0;
      a = 0;
      while (!a && n < 200) begin
         tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, u, l,
              rnd ? ($urandom_range(0, 3) != 0) : 1'b1, a);
         n++;
      end
      if (!a) check_value("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_row(input bit sof, input int len, input bit with_tlast, input bit rnd);
      for (int i = 0; i < len; i++)
         send_beat(sof && i == 0, with_tlast && i == len - 1, rnd);
   endtask

   task automatic send_frame(input int w, input int h, input bit rnd);
      for (int r = 0; r < h; r++) send_row(r == 0, w, 1'b1, rnd);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_regs();
      rst = 1'b0;
      io.s_tvalid = 1'b0; io.s_tuser = 1'b0; io.s_tlast = 1'b0; io.dn_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_regs();
      check_value("reset_lb_we", io.lb_we, 0);
      check_value("reset_lb_addr", io.lb_addr, 0);
      check_value("reset_lb_wsel", io.lb_wsel, 0);
   endtask

   task automatic clear_counts();
      n_valid = 0; n_tuser = 0; n_tlast = 0; n_err = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      io.s_tvalid = 1'b0; io.s_tuser = 1'b0; io.s_tlast = 1'b0; io.dn_ready = 1'b0;
      model_reset();
      clear_counts();
      do_reset();

      // continuous 20x10 frame
      clear_counts();
      send_frame(20, 10, 1'b0);
      idle(2);
      check_value("cont_n_valid", n_valid, 56);
      check_value("cont_n_tuser", n_tuser, 1);
      check_value("cont_n_tlast", n_tlast, 4);
      check_value("cont_n_err", n_err, 0);

      // same frame with random valid/ready
      do_reset();
      clear_counts();
      send_frame(20, 10, 1'b1);
      idle(2);
      check_value("rnd_n_valid", n_valid, 56);
      check_value("rnd_n_tlast", n_tlast, 4);
      check_value("rnd_n_err", n_err, 0);

      // early tlast on row 3, missing tlast on row 8
      do_reset();
      clear_counts();
      for (int r = 0; r < 10; r++)
         send_row(r == 0, (r == 3) ? 13 : 20, r != 8, 1'b1);
      idle(2);
      check_value("eol_n_err", n_err, 2);

      // tuser at row 5 col 7, then a fresh 20x8 frame
      do_reset();
      for (int r = 0; r < 5; r++) send_row(r == 0, 20, 1'b1, 1'b1);
      send_row(1'b0, 7, 1'b0, 1'b1);
      clear_counts();
      send_frame(20, 8, 1'b1);
      idle(2);
      check_value("sof_n_err", n_err, 1);
      check_value("sof_n_valid", n_valid, 28);

      // reset mid-RUN, stray beats, then a small frame
      for (int r = 0; r < 3; r++) send_row(r == 0, 12, 1'b1, 1'b0);
      send_row(1'b0, 5, 1'b0, 1'b0);
      do_reset();
      send_row(1'b0, 10, 1'b1, 1'b1);
      clear_counts();
      send_frame(8, 7, 1'b0);
      idle(2);
      check_value("post_reset_n_valid", n_valid, 2);

      // short first line, then ignored beats
      send_row(1'b1, 4, 1'b1, 1'b0);
      send_row(1'b0, 5, 1'b1, 1'b0);
      idle(2);

      // first line never terminated: width saturates at MAX_WIDTH
      send_row(1'b1, 40, 1'b0, 1'b0);
      send_row(1'b0, 32, 1'b1, 1'b0);
      idle(2);

      // random frames with occasional malformed lines
      for (int f = 0; f < 12; f++) begin
         int w, h;
         w = $urandom_range(5, 26);
         h = $urandom_range(6, 12);
         for (int r = 0; r < h; r++)
            send_row(r == 0, ($urandom_range(0, 7) == 0) ? $urandom_range(1, w + 4) : w,
                     $urandom_range(0, 7) != 0, 1'b1);
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
